// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter FSM states, command bytes and the
// default timing constants (50 MHz system clock).
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        INHIBIT   = 3'd1,
        RTS       = 3'd2,
        DATA      = 3'd3,
        ACK       = 3'd4,
        WAIT_IDLE = 3'd5
    } ps2_state_e;

    localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
    localparam logic [7:0] PS2_CMD_ENABLE  = 8'hF4;
    localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;
    localparam logic [7:0] PS2_ACK_BYTE    = 8'hFA;

    // 100 us clock inhibit and 15 ms response window at 50 MHz
    localparam int unsigned PS2_INHIBIT_CYCLES_DEF = 5000;
    localparam int unsigned PS2_TIMEOUT_CYCLES_DEF = 750000;

    // PS/2 frames carry odd parity: data bits plus parity hold an odd number of ones
    function automatic logic ps2_odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchroniser for the PS/2 clock and data pins plus a registered
// falling-edge detector on the clock. A pin edge shows up on clk_fall three
// clk cycles later. Shared with the PS/2 receive path.
module ps2_sync_edge (
    input  logic clk,
    input  logic clrn,
    input  logic ps2_clk_in,
    input  logic ps2_data_in,
    output logic clk_sync,
    output logic data_sync,
    output logic clk_fall
);

    logic [1:0] clk_ff;
    logic [1:0] data_ff;
    logic       clk_prev;

    // Synchronise both pins (idle bus level is high) and flag clock falls
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            clk_ff   <= 2'b11;
            data_ff  <= 2'b11;
            clk_prev <= 1'b1;
            clk_fall <= 1'b0;
        end else begin
            clk_ff   <= {clk_ff[0], ps2_clk_in};
            data_ff  <= {data_ff[0], ps2_data_in};
            clk_prev <= clk_ff[1];
            clk_fall <= clk_prev & ~clk_ff[1];
        end
    end

    assign clk_sync  = clk_ff[1];
    assign data_sync = data_ff[1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter. Inhibits the bus, issues a
// request-to-send, shifts out 8 data bits LSB first plus odd parity on the
// device-generated clock, releases for the stop bit and samples the device
// ACK. Pins are open-collector: *_oe = 1 pulls the line low.
//
// Optional build macro PS2_HOST_TX_TIMEOUT_EN: when defined, a frame that
// is not finished within TIMEOUT_CYCLES of clock release is abandoned with
// tx_err. When undefined the FSM waits for the device indefinitely.
//
// Handshake: a command byte is taken on any clk edge where tx_valid and
// tx_ready are both high; tx_ready is high only in IDLE, and tx_valid is
// ignored at all other times (no queueing).
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES = PS2_INHIBIT_CYCLES_DEF,
    parameter int unsigned TIMEOUT_CYCLES = PS2_TIMEOUT_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       tx_done,
    output logic       tx_err,
    output logic       busy,
    output ps2_state_e state_dbg
);

    localparam int unsigned IW = $clog2(INHIBIT_CYCLES + 1);
    localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);

    ps2_state_e    state;
    ps2_state_e    state_nxt;
    logic [IW-1:0] inh_cnt;
    logic [3:0]    bit_idx;     // device clock falls seen since RTS
    logic [8:0]    shreg;       // {parity, data}; bit 0 is the bit on the wire
    logic          ack_ok;
    logic          clk_sync;
    logic          data_sync;
    logic          clk_fall;
    logic          timeout;

    ps2_sync_edge u_sync (
        .clk         (clk),
        .clrn        (clrn),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_data_in (ps2_data_in),
        .clk_sync    (clk_sync),
        .data_sync   (data_sync),
        .clk_fall    (clk_fall)
    );

`ifdef PS2_HOST_TX_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LIMIT = TW'(TIMEOUT_CYCLES);

    logic [TW-1:0] to_cnt;

    // Count cycles since clock release; held at zero until RTS is reached
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            to_cnt <= '0;
        end else if (state == IDLE || state == INHIBIT) begin
            to_cnt <= '0;
        end else if (to_cnt != TO_LIMIT) begin
            to_cnt <= to_cnt + TW'(1);
        end
    end

    assign timeout = (state != IDLE) && (state != INHIBIT) && (to_cnt == TO_LIMIT);
`else
    wire unused_timeout_cycles = ^TIMEOUT_CYCLES;
    assign timeout = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, pin drives and result pulses; a timeout overrides everything
    always_comb begin
        state_nxt   = state;
        ps2_clk_oe  = 1'b0;
        ps2_data_oe = 1'b0;
        tx_done     = 1'b0;
        tx_err      = 1'b0;
        case (state)
            IDLE: begin
                if (tx_valid) state_nxt = INHIBIT;
            end
            INHIBIT: begin
                ps2_clk_oe = 1'b1;
                if (inh_cnt == INH_LAST) begin
                    ps2_data_oe = 1'b1;     // start bit goes low before clock release
                    state_nxt   = RTS;
                end
            end
            RTS: begin
                ps2_data_oe = 1'b1;
                if (clk_fall) state_nxt = DATA;
            end
            DATA: begin
                ps2_data_oe = ~shreg[0];
                if (clk_fall && bit_idx == 4'd9) state_nxt = ACK;
            end
            ACK: begin
                if (clk_fall) state_nxt = WAIT_IDLE;
            end
            WAIT_IDLE: begin
                if (clk_sync && data_sync) begin
                    tx_done   = ack_ok;
                    tx_err    = ~ack_ok;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (timeout) begin
            state_nxt   = IDLE;
            ps2_clk_oe  = 1'b0;
            ps2_data_oe = 1'b0;
            tx_done     = 1'b0;
            tx_err      = 1'b1;
        end
    end

    // Frame datapath: latch the byte, time the inhibit, shift bits on clock falls
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            inh_cnt <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            ack_ok  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (tx_valid) begin
                        shreg   <= {ps2_odd_parity(tx_data), tx_data};
                        inh_cnt <= '0;
                        bit_idx <= '0;
                        ack_ok  <= 1'b0;
                    end
                end
                INHIBIT: inh_cnt <= inh_cnt + IW'(1);
                RTS: begin
                    if (clk_fall) bit_idx <= bit_idx + 4'd1;
                end
                DATA: begin
                    if (clk_fall) begin
                        bit_idx <= bit_idx + 4'd1;
                        shreg   <= shreg >> 1;
                    end
                end
                ACK: begin
                    if (clk_fall) ack_ok <= ~data_sync;
                end
                default: ;
            endcase
        end
    end

    assign tx_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign state_dbg = state;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-collector bus model, a PS/2 device model that
// clocks frames in and ACKs or NACKs, and per-scenario checks against a
// frame model computed from the byte (LSB-first data, odd parity, stop 1).
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int INH  = 2000;
  localparam int TMO  = 3000;
  localparam int HALF = 30;

  logic       clk = 1'b0;
  logic       clrn = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, ps2_clk_oe, ps2_data_oe, tx_done, tx_err, busy;
  ps2_state_e state_dbg;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;
  wire        ps2_clk_line  = ~(ps2_clk_oe | dev_clk_low);
  wire        ps2_data_line = ~(ps2_data_oe | dev_data_low);

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;
  int ready_hi_cnt = 0;
  bit in_frame = 1'b0;
  logic [9:0] exp_q[$];

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .clrn(clrn), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .ps2_clk_in(ps2_clk_line), .ps2_data_in(ps2_data_line),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe), .tx_done(tx_done),
    .tx_err(tx_err), .busy(busy), .state_dbg(state_dbg)
  );

  // clock
  always #10 clk = ~clk;

  // pulse and handshake monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (tx_done === 1'b1) done_cnt++;
    if (tx_err === 1'b1) err_cnt++;
    if (tx_done === 1'b1 && tx_err === 1'b1) both_cnt++;
    if (in_frame && tx_ready === 1'b1) ready_hi_cnt++;
  end

  // reference frame as seen by the device: data LSB first, odd parity, stop
  function automatic logic [9:0] model_frame(input logic [7:0] b);
    int ones = 0;
    for (int i = 0; i < 8; i++) if (b[i]) ones++;
    return {1'b1, (ones % 2 == 0) ? 1'b1 : 1'b0, b};
  endfunction

  // driver: present a byte for one accepting edge
  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    while (tx_ready !== 1'b1 && t < 1000) begin @(negedge clk); t++; end
    tx_data = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  // inhibit length and data drive at clock release
  task automatic measure_inhibit(output int len, output logic drel);
    len = 0;
    while (ps2_clk_oe === 1'b1 && len < 4 * INH) begin @(negedge clk); len++; end
    drel = ps2_data_oe;
  endtask

  // device model: waits for request-to-send, generates nfalls clocks,
  // samples data on each rising edge, and answers the 11th clock with ACK/NACK
  task automatic dev_run(input bit do_ack, input int nfalls, output logic [9:0] seen, output bit ok);
    int t = 0;
    ok = 1'b0;
    seen = '0;
    while (ps2_clk_oe !== 1'b1 && t < 4 * INH) begin @(negedge clk); t++; end
    while (ps2_clk_oe === 1'b1 && t < 4 * INH) begin @(negedge clk); t++; end
    if (t >= 4 * INH || ps2_data_line !== 1'b0) return;
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      dev_clk_low = 1'b1;
      if (i == nfalls - 1) begin
        repeat (HALF / 2) @(negedge clk);
        ok = 1'b1;
        return;
      end
      repeat (HALF) @(negedge clk);
      dev_clk_low = 1'b0;
      repeat (HALF / 2) @(negedge clk);
      seen[i] = ps2_data_line;
      repeat (HALF - HALF / 2) @(negedge clk);
    end
    if (do_ack) dev_data_low = 1'b1;
    repeat (HALF / 2) @(negedge clk);
    dev_clk_low = 1'b1;
    repeat (HALF) @(negedge clk);
    dev_clk_low = 1'b0;
    repeat (HALF) @(negedge clk);
    dev_data_low = 1'b0;
    ok = 1'b1;
  endtask

  task automatic wait_result(input int budget, output int n);
    n = 0;
    while (tx_done !== 1'b1 && tx_err !== 1'b1 && n < budget) begin @(negedge clk); n++; end
  endtask

  task automatic test_reset();
    clrn = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (tx_ready !== 1'b1 || busy !== 1'b0 || state_dbg !== IDLE) begin
      errors++; $display("FAIL reset_ready: ready=%b busy=%b state=%0d expected 1 0 0", tx_ready, busy, state_dbg);
    end
    checks++;
    if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0 || tx_done !== 1'b0 || tx_err !== 1'b0) begin
      errors++; $display("FAIL reset_outputs: clk_oe=%b data_oe=%b done=%b err=%b expected all 0", ps2_clk_oe, ps2_data_oe, tx_done, tx_err);
    end
    clrn = 1'b1;
    repeat (3) @(negedge clk);
    // asynchronous release while inhibiting
    send_byte(8'hA5);
    repeat (10) @(negedge clk);
    checks++;
    if (ps2_clk_oe !== 1'b1) begin
      errors++; $display("FAIL inhibit_active: clk_oe=%b expected 1", ps2_clk_oe);
    end
    #4 clrn = 1'b0;
    #1;
    checks++;
    if (ps2_clk_oe !== 1'b0 || tx_ready !== 1'b1) begin
      errors++; $display("FAIL async_reset_inhibit: clk_oe=%b ready=%b expected 0 1", ps2_clk_oe, tx_ready);
    end
    @(negedge clk);
    clrn = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_ed_ack();
    logic [9:0] seen, exp;
    logic drel;
    bit ok;
    int len, n, d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    exp_q.push_back(model_frame(PS2_CMD_SET_LED));
    send_byte(PS2_CMD_SET_LED);
    fork
      measure_inhibit(len, drel);
      dev_run(1'b1, 11, seen, ok);
    join
    wait_result(1000, n);
    repeat (4) @(negedge clk);
    exp = exp_q.pop_front();
    checks++;
    if (len != INH) begin errors++; $display("FAIL ed_inhibit_len: got %0d expected %0d", len, INH); end
    checks++;
    if (drel !== 1'b1) begin errors++; $display("FAIL ed_start_bit: data_oe=%b expected 1", drel); end
    checks++;
    if (!ok || seen !== exp || exp !== 10'b1_1_1110_1101) begin
      errors++; $display("FAIL ed_bits: got %b expected %b", seen, exp);
    end
    checks++;
    if (done_cnt - d0 != 1 || err_cnt - e0 != 0) begin
      errors++; $display("FAIL ed_result: done=%0d err=%0d expected 1 0", done_cnt - d0, err_cnt - e0);
    end
    checks++;
    if (tx_ready !== 1'b1) begin errors++; $display("FAIL ed_idle: ready=%b expected 1", tx_ready); end
  endtask

  task automatic test_f4_nack();
    logic [9:0] seen, exp;
    logic drel;
    bit ok;
    int len, n, d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    exp_q.push_back(model_frame(PS2_CMD_ENABLE));
    send_byte(PS2_CMD_ENABLE);
    fork
      measure_inhibit(len, drel);
      dev_run(1'b0, 11, seen, ok);
    join
    wait_result(1000, n);
    repeat (4) @(negedge clk);
    exp = exp_q.pop_front();
    checks++;
    if (!ok || seen !== exp || seen[8] !== 1'b0) begin
      errors++; $display("FAIL f4_bits: got %b expected %b", seen, exp);
    end
    checks++;
    if (done_cnt - d0 != 0 || err_cnt - e0 != 1) begin
      errors++; $display("FAIL f4_nack: done=%0d err=%0d expected 0 1", done_cnt - d0, err_cnt - e0);
    end
  endtask

  task automatic test_random();
    logic [9:0] seen, exp;
    logic [7:0] b;
    logic drel;
    bit ok, ack;
    int len, n, d0, e0;
    for (int k = 0; k < 3; k++) begin
      b = 8'($urandom_range(0, 255));
      ack = 1'($urandom_range(0, 1));
      d0 = done_cnt; e0 = err_cnt;
      exp_q.push_back(model_frame(b));
      send_byte(b);
      fork
        measure_inhibit(len, drel);
        dev_run(ack, 11, seen, ok);
      join
      wait_result(1000, n);
      repeat (4) @(negedge clk);
      exp = exp_q.pop_front();
      checks++;
      if (!ok || seen !== exp || len != INH) begin
        errors++; $display("FAIL rand_bits: byte %h got %b len %0d expected %b len %0d", b, seen, len, exp, INH);
      end
      checks++;
      if (done_cnt - d0 != int'(ack) || err_cnt - e0 != int'(!ack)) begin
        errors++; $display("FAIL rand_result: byte %h done=%0d err=%0d expected %0d %0d", b, done_cnt - d0, err_cnt - e0, ack, !ack);
      end
    end
    checks++;
    if (both_cnt != 0) begin errors++; $display("FAIL done_err_overlap: got %0d expected 0", both_cnt); end
  endtask

  task automatic test_timeout();
    logic drel;
    int len, n, e0;
    e0 = err_cnt;
    send_byte(8'h00);
    measure_inhibit(len, drel);
`ifdef PS2_HOST_TX_TIMEOUT_EN
    n = 0;
    while (tx_err !== 1'b1 && n < TMO + 100) begin @(negedge clk); n++; end
    checks++;
    if (n != TMO) begin errors++; $display("FAIL timeout_latency: got %0d expected %0d", n, TMO); end
    checks++;
    if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) begin
      errors++; $display("FAIL timeout_release: clk_oe=%b data_oe=%b expected 0 0", ps2_clk_oe, ps2_data_oe);
    end
    @(negedge clk);
    checks++;
    if (tx_ready !== 1'b1 || err_cnt - e0 != 1) begin
      errors++; $display("FAIL timeout_idle: ready=%b err=%0d expected 1 1", tx_ready, err_cnt - e0);
    end
`else
    n = 0;
    for (int i = 0; i < 3 * TMO; i++) begin
      @(negedge clk);
      if (busy !== 1'b1) n++;
    end
    checks++;
    if (n != 0 || err_cnt - e0 != 0) begin
      errors++; $display("FAIL no_timeout: busy_low=%0d err=%0d expected 0 0", n, err_cnt - e0);
    end
    checks++;
    if (state_dbg !== RTS || ps2_data_oe !== 1'b1 || ps2_clk_oe !== 1'b0) begin
      errors++; $display("FAIL no_timeout_rts: state=%0d data_oe=%b clk_oe=%b expected %0d 1 0", state_dbg, ps2_data_oe, ps2_clk_oe, RTS);
    end
    clrn = 1'b0;
    repeat (2) @(negedge clk);
    clrn = 1'b1;
    repeat (3) @(negedge clk);
`endif
  endtask

  task automatic test_reset_mid_frame();
    logic [9:0] seen, exp;
    logic drel;
    bit ok;
    int len, n, d0, e0;
    send_byte(PS2_CMD_RESET);
    fork
      measure_inhibit(len, drel);
      dev_run(1'b1, 5, seen, ok);
    join
    checks++;
    if (!ok || busy !== 1'b1) begin errors++; $display("FAIL midframe_busy: busy=%b expected 1", busy); end
    #3 clrn = 1'b0;
    #1;
    checks++;
    if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0 || tx_ready !== 1'b1) begin
      errors++; $display("FAIL midframe_reset: clk_oe=%b data_oe=%b ready=%b expected 0 0 1", ps2_clk_oe, ps2_data_oe, tx_ready);
    end
    dev_clk_low = 1'b0;
    repeat (2) @(negedge clk);
    clrn = 1'b1;
    repeat (5) @(negedge clk);
    d0 = done_cnt; e0 = err_cnt;
    exp_q.push_back(model_frame(PS2_CMD_ENABLE));
    send_byte(PS2_CMD_ENABLE);
    fork
      measure_inhibit(len, drel);
      dev_run(1'b1, 11, seen, ok);
    join
    wait_result(1000, n);
    repeat (4) @(negedge clk);
    exp = exp_q.pop_front();
    checks++;
    if (!ok || seen !== exp || done_cnt - d0 != 1 || err_cnt - e0 != 0) begin
      errors++; $display("FAIL after_reset_frame: got %b done=%0d err=%0d expected %b 1 0", seen, done_cnt - d0, err_cnt - e0, exp);
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0] seen, exp;
    logic drel;
    bit ok;
    int len, n, d0, rh0;
    d0 = done_cnt;
    while (tx_ready !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
    exp_q.push_back(model_frame(PS2_CMD_RESET));
    exp_q.push_back(model_frame(PS2_CMD_ENABLE));
    tx_data = PS2_CMD_RESET;
    tx_valid = 1'b1;
    @(negedge clk);
    in_frame = 1'b1;
    rh0 = ready_hi_cnt;
    tx_data = PS2_CMD_ENABLE;
    fork
      measure_inhibit(len, drel);
      dev_run(1'b1, 11, seen, ok);
    join
    wait_result(1000, n);
    in_frame = 1'b0;
    exp = exp_q.pop_front();
    checks++;
    if (!ok || seen !== exp) begin errors++; $display("FAIL b2b_first_bits: got %b expected %b", seen, exp); end
    checks++;
    if (ready_hi_cnt - rh0 != 0) begin
      errors++; $display("FAIL b2b_ready_low: ready high %0d cycles expected 0", ready_hi_cnt - rh0);
    end
    checks++;
    if (tx_done !== 1'b1 || ps2_clk_oe !== 1'b0) begin
      errors++; $display("FAIL b2b_done_first: done=%b clk_oe=%b expected 1 0", tx_done, ps2_clk_oe);
    end
    @(negedge clk);
    checks++;
    if (tx_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_after: ready=%b expected 1", tx_ready); end
    @(negedge clk);
    tx_valid = 1'b0;
    checks++;
    if (ps2_clk_oe !== 1'b1 || tx_ready !== 1'b0) begin
      errors++; $display("FAIL b2b_second_start: clk_oe=%b ready=%b expected 1 0", ps2_clk_oe, tx_ready);
    end
    fork
      measure_inhibit(len, drel);
      dev_run(1'b1, 11, seen, ok);
    join
    wait_result(1000, n);
    repeat (4) @(negedge clk);
    exp = exp_q.pop_front();
    checks++;
    if (!ok || seen !== exp || done_cnt - d0 != 2) begin
      errors++; $display("FAIL b2b_second_frame: got %b done=%0d expected %b 2", seen, done_cnt - d0, exp);
    end
  endtask

  initial begin
    test_reset();
    test_ed_ack();
    test_f4_nack();
    test_random();
    test_timeout();
    test_reset_mid_frame();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3_000_000;
    errors++;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- PS/2 host-to-device transmitter. It sends one command byte to the keyboard, for example 0xED for set-LEDs, 0xF4 for enable, or 0xFF for reset.
- It is the opposite direction of the existing keyboard receive path (scan code → ASCII → key-enable pulse).
- It sits beside the PS/2 receiver and shares the open-collector ps2_clk/ps2_data pins through output-enable signals.
- It reports a done pulse on device ACK and an error pulse on NACK or timeout.

Parameters:
- INHIBIT_CYCLES, 5000: clk cycles ps2_clk is held low before request-to-send (100 us at 50 MHz).
- TIMEOUT_CYCLES, 750000: max clk cycles from clock release to ACK (15 ms at 50 MHz).

Ports:
- clk  in  1  system clock (single clock domain).
- clrn  in  1  asynchronous active-low reset.
- tx_data  in  8  command byte.
- tx_valid  in  1  request; byte is accepted when tx_valid && tx_ready.
- tx_ready  out  1  high only in IDLE.
- ps2_clk_in  in  1  raw PS/2 clock pin level (asynchronous).
- ps2_data_in  in  1  raw PS/2 data pin level (asynchronous).
- ps2_clk_oe  out  1  1 = drive ps2_clk low; 0 = release.
- ps2_data_oe  out  1  1 = drive ps2_data low; 0 = release.
- tx_done  out  1  one-cycle pulse: device ACKed.
- tx_err  out  1  one-cycle pulse: NACK or timeout.
- busy  out  1  high in any state other than IDLE; the receiver ignores traffic while busy.

Behaviour:
- Reset (clrn low, asynchronous):
  - State goes to IDLE.
  - All outputs 0 except tx_ready=1.
  - Counters and shift register cleared.
  - Pins are released immediately, including mid-frame.
- Input sync: ps2_clk_in and ps2_data_in each pass through a 2-FF synchroniser.
  - fall = previous synced clock 1 and current synced clock 0.
  - Edge detection latency is 3 clk cycles.
- IDLE:
  - On tx_valid && tx_ready: latch tx_data.
  - Compute parity = ~^tx_data (odd parity).
  - Next state INHIBIT.
- INHIBIT:
  - ps2_clk_oe=1 for exactly INHIBIT_CYCLES cycles.
  - On the last cycle, ps2_data_oe goes to 1 (start bit 0).
  - Next state RTS.
- RTS:
  - ps2_clk_oe=0 and ps2_data_oe=1.
  - Timeout counter starts.
  - Bit index bit_idx=0.
- Bit timing, counting falling edges in RTS/DATA:
  - Falls 1..8: drive data bit bit_idx-1, LSB first, with ps2_data_oe = ~bit.
  - Fall 9: drive the parity bit.
  - Fall 10: release data (stop bit = 1); next state ACK.
  - The state is named DATA after fall 1.
- ACK:
  - On the next fall, sample synced data.
  - Data 0 → WAIT_IDLE with ack_ok=1; data 1 → WAIT_IDLE with ack_ok=0.
- WAIT_IDLE:
  - Wait until synced clock and synced data are both 1.
  - Then pulse tx_done (if ack_ok) or tx_err (if not), and return to IDLE.
  - tx_ready rises on the cycle after the pulse.
- Timeout: if the counter reaches TIMEOUT_CYCLES in RTS/DATA/ACK/WAIT_IDLE:
  - Release both pins.
  - Pulse tx_err.
  - Return to IDLE.
- tx_valid is ignored while not in IDLE; there is no queueing.
- If tx_valid is held after done, a new frame starts on the next IDLE cycle.
- Counter widths are $clog2(param+1).
- tx_done and tx_err are never high in the same cycle.

Optional Feature:
- Macro PS2_HOST_TX_TIMEOUT_EN.
- Defined: timeout logic as above.
- Undefined:
  - No timeout counter.
  - The FSM waits indefinitely for clock edges.
  - tx_err pulses only on NACK.
  - TIMEOUT_CYCLES is unused.

Decomposition:
- Package ps2_pkg holds:
  - The FSM state enum: IDLE, INHIBIT, RTS, DATA, ACK, WAIT_IDLE.
  - Command constants: PS2_CMD_SET_LED=8'hED, PS2_CMD_ENABLE=8'hF4, PS2_CMD_RESET=8'hFF, PS2_ACK_BYTE=8'hFA.
  - Default timing constants.
- One sub-module, ps2_sync_edge: 2-FF synchroniser plus falling-edge detector for ps2_clk, with synced data passthrough. The existing receiver also reuses it.

Test Plan:
- Send 0xED with the device model clocking at 12 kHz and ACKing:
  - ps2_clk_oe high for exactly 5000 cycles.
  - Data bits seen by the device on rising edges are 1,0,1,1,0,1,1,1, then parity 1, then stop 1.
  - tx_done pulses once; tx_err stays 0.
- Send 0xF4 with the device NACKing (data high at ACK fall): parity 0 observed; tx_err pulses once; tx_done stays 0.
- Send 0x00 with the device never clocking, macro defined:
  - tx_err pulses 750000 cycles after clock release.
  - Pins are released and tx_ready=1.
- Same as the previous case with the macro undefined: busy stays 1 for 2M cycles and no err pulse occurs.
- Assert clrn low at fall 5 of 0xFF:
  - Both oe go to 0 asynchronously and tx_ready=1.
  - A following send of 0xF4 completes normally.
- Hold tx_valid high through a frame (0xFF, then 0xF4 presented):
  - The second frame starts only after tx_done.
  - tx_ready is low throughout the first frame.
